// File: rtl/sysctrl_pkg.sv
// sysctrl_pkg: shared definitions for the system controller.
// Holds the command opcodes and the receive-FSM state encoding. The encoding
// is kept as plain localparams so the transmit side can reference the same
// values without pulling in the enum type.
package sysctrl_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_WR_ADDR   = 4'd1;
  localparam logic [3:0] ST_WR_DATA   = 4'd2;
  localparam logic [3:0] ST_RD_ADDR   = 4'd3;
  localparam logic [3:0] ST_OP_A      = 4'd4;
  localparam logic [3:0] ST_OP_B      = 4'd5;
  localparam logic [3:0] ST_FUN       = 4'd6;
  localparam logic [3:0] ST_ISSUE_RD  = 4'd7;
  localparam logic [3:0] ST_ISSUE_ALU = 4'd8;

  typedef enum logic [3:0] {
    IDLE      = ST_IDLE,
    WR_ADDR   = ST_WR_ADDR,
    WR_DATA   = ST_WR_DATA,
    RD_ADDR   = ST_RD_ADDR,
    OP_A      = ST_OP_A,
    OP_B      = ST_OP_B,
    FUN       = ST_FUN,
    ISSUE_RD  = ST_ISSUE_RD,
    ISSUE_ALU = ST_ISSUE_ALU
  } rx_state_e;

endpackage

// File: rtl/sysctrl_rxfsm_if.sv
// sysctrl_rxfsm_if: byte-stream input and RF/ALU command outputs of the
// receive decoder.
//   master: byte source / command consumer side (drives RX_*, TX_BUSY)
//   slave : the decoder (drives RF strobes, Address, WrData, ALU_*, CMD_ERR)
interface sysctrl_rxfsm_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic [7:0]            RX_P_DATA;
  logic                  RX_D_VLD;
  logic                  TX_BUSY;
  logic                  WrEn;
  logic                  RdEn;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] WrData;
  logic                  ALU_EN;
  logic [3:0]            ALU_FUN;
  logic [DATA_WIDTH-1:0] ALU_A;
  logic [DATA_WIDTH-1:0] ALU_B;
  logic                  CMD_ERR;

  modport master (
    output RX_P_DATA, RX_D_VLD, TX_BUSY,
    input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, ALU_A, ALU_B, CMD_ERR
  );

  modport slave (
    input  RX_P_DATA, RX_D_VLD, TX_BUSY,
    output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, ALU_A, ALU_B, CMD_ERR
  );
endinterface

// File: rtl/sysctrl_byte_assembler.sv
// sysctrl_byte_assembler: collects NB = DATA_WIDTH/8 bytes little-endian.
//   i_load  : accept i_byte into lane r_cnt, advance counter
//   i_clr   : clear counter (has priority over load)
//   o_cnt   : current byte index
//   o_done  : this load carries the last byte of the word
//   o_word  : shadow register including the byte being loaded this cycle,
//             so the caller can commit the full word on the o_done edge
module sysctrl_byte_assembler #(
  parameter int DATA_WIDTH = 32,
  localparam int NB = DATA_WIDTH / 8,
  localparam int CW = $clog2(NB) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_clr,
  input  logic [7:0]            i_byte,
  output logic [CW-1:0]         o_cnt,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_word
);
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_shadow;
  logic [DATA_WIDTH-1:0] w_word;

  always_comb begin
    w_word = r_shadow;
    if (i_load) w_word[int'(r_cnt)*8 +: 8] = i_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_shadow <= '0;
    end else begin
      if (i_clr)       r_cnt <= '0;
      else if (i_load) r_cnt <= r_cnt + 1'b1;
      // Lanes are fully overwritten each frame, so the shadow is never cleared.
      if (i_load) r_shadow <= w_word;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_done = i_load && (r_cnt == CW'(NB - 1));
  assign o_word = w_word;
endmodule

// File: rtl/sysctrl_rxfsm.sv
// sysctrl_rxfsm: receive-side command decoder of the system controller.
//   clk, RST : clock, asynchronous active-high reset
//   bus      : slave side of sysctrl_rxfsm_if (bytes in, RF/ALU commands out)
// Frames: AA addr d[NB] (RF write), BB addr (RF read),
//         CC a[NB] b[NB] fun (ALU), DD fun (ALU on held operands).
// Read and ALU issue wait for the transmit path to be idle.
module sysctrl_rxfsm
  import sysctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  localparam int NB = DATA_WIDTH / 8,
  localparam int CW = $clog2(NB) + 1
) (
  input logic           clk,
  input logic           RST,
  sysctrl_rxfsm_if.slave bus
);
  rx_state_e             r_state;
  logic                  r_wren, r_rden, r_alu_en, r_cmd_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wrdata, r_alu_a, r_alu_b;
  logic [3:0]            r_alu_fun;

  logic                  w_collect, w_load, w_clr, w_done;
  logic [CW-1:0]         w_cnt;
  logic [DATA_WIDTH-1:0] w_word;

  assign w_collect = (r_state == WR_DATA) || (r_state == OP_A) || (r_state == OP_B);
  assign w_load    = bus.RX_D_VLD && w_collect;
  // Counter only runs inside collecting states and is left on done, so
  // holding it clear elsewhere is equivalent to clearing on each state change.
  assign w_clr     = !w_collect || w_done;

  sysctrl_byte_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
    .clk    (clk),
    .rst    (RST),
    .i_load (w_load),
    .i_clr  (w_clr),
    .i_byte (bus.RX_P_DATA),
    .o_cnt  (w_cnt),
    .o_done (w_done),
    .o_word (w_word)
  );

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_wren    <= 1'b0;
      r_rden    <= 1'b0;
      r_alu_en  <= 1'b0;
      r_cmd_err <= 1'b0;
      r_addr    <= '0;
      r_wrdata  <= '0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_fun <= '0;
    end else begin
      r_wren    <= 1'b0;
      r_rden    <= 1'b0;
      r_alu_en  <= 1'b0;
      r_cmd_err <= 1'b0;
      case (r_state)
        IDLE: if (bus.RX_D_VLD) begin
          case (bus.RX_P_DATA)
            CMD_RF_WR:   r_state <= WR_ADDR;
            CMD_RF_RD:   r_state <= RD_ADDR;
            CMD_ALU_OP:  r_state <= OP_A;
            CMD_ALU_NOP: r_state <= FUN;
            default:     r_cmd_err <= 1'b1;
          endcase
        end
        WR_ADDR: if (bus.RX_D_VLD) begin
          r_addr  <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
          r_state <= WR_DATA;
        end
        WR_DATA: if (w_done) begin
          r_wrdata <= w_word;
          r_wren   <= 1'b1;
          r_state  <= IDLE;
        end
        RD_ADDR: if (bus.RX_D_VLD) begin
          r_addr  <= bus.RX_P_DATA[ADDR_WIDTH-1:0];
          r_state <= ISSUE_RD;
        end
        OP_A: if (w_done) begin
          r_alu_a <= w_word;
          r_state <= OP_B;
        end
        OP_B: if (w_done) begin
          r_alu_b <= w_word;
          r_state <= FUN;
        end
        FUN: if (bus.RX_D_VLD) begin
          r_alu_fun <= bus.RX_P_DATA[3:0];
          r_state   <= ISSUE_ALU;
        end
        // Bytes arriving while waiting to issue are dropped.
        ISSUE_RD: if (!bus.TX_BUSY) begin
          r_rden  <= 1'b1;
          r_state <= IDLE;
        end
        ISSUE_ALU: if (!bus.TX_BUSY) begin
          r_alu_en <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.WrEn    = r_wren;
  assign bus.RdEn    = r_rden;
  assign bus.ALU_EN  = r_alu_en;
  assign bus.CMD_ERR = r_cmd_err;
  assign bus.Address = r_addr;
  assign bus.WrData  = r_wrdata;
  assign bus.ALU_A   = r_alu_a;
  assign bus.ALU_B   = r_alu_b;
  assign bus.ALU_FUN = r_alu_fun;
endmodule
